xoodyak_sequencer: RTL and testbench

Command sequencer in front of `xoodyak_build`. It accepts Xoodyak API commands from a host over a valid/ready handshake and checks each one against the Cyclist mode rules. Legal commands are driven onto the core's `opmode`/`input_data` pins for a fixed hold window. The sequencer then waits for the core's completion pulse and returns a one-beat response, including an error flag, to the host.

---
 rtl/xoodyak_pkg.sv | 57 +++++
 rtl/xoodyak_mode_check.sv | 61 ++++++
 rtl/xoodyak_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_xoodyak_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xoodyak_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xoodyak_pkg
// Description : Shared definitions for the Xoodyak command sequencer.
//               - Command op-codes.
//               - Cyclist mode and FSM state enums.
//               - Command legality function.
// Revision    : 1.0 - initial release
// ============================================================================
package xoodyak_pkg;

  // Command op-codes (4-bit host encoding)
  localparam logic [3:0] OP_IDLE        = 4'd0;
  localparam logic [3:0] OP_INIT_KEYED  = 4'd1;
  localparam logic [3:0] OP_NONCE       = 4'd2;
  localparam logic [3:0] OP_ABSORB      = 4'd3;
  localparam logic [3:0] OP_ENCRYPT     = 4'd4;
  localparam logic [3:0] OP_DECRYPT     = 4'd5;
  localparam logic [3:0] OP_SQUEEZE     = 4'd6;
  localparam logic [3:0] OP_RATCHET     = 4'd7;
  localparam logic [3:0] OP_SQUEEZE_KEY = 4'd8;
  localparam logic [3:0] OP_INIT_HASH   = 4'd9;

  // Cyclist mode the core is currently in
  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_HASH  = 2'd1,
    MODE_KEYED = 2'd2
  } mode_e;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Returns 1 when op may be issued given the current mode and whether the
  // most recent completed legal op was a keyed init.
  function automatic logic legal_cmd(input logic [3:0] op,
                                     input mode_e      mode,
                                     input logic       after_init);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_INIT_KEYED, OP_INIT_HASH:                       ok = 1'b1;
      OP_NONCE:                                          ok = after_init;
      OP_ENCRYPT, OP_DECRYPT, OP_RATCHET, OP_SQUEEZE_KEY: ok = (mode == MODE_KEYED);
      OP_ABSORB, OP_SQUEEZE:                             ok = (mode != MODE_NONE);
      default:                                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xoodyak_mode_check.sv
`default_nettype none
// ============================================================================
// Module      : xoodyak_mode_check
// Description : Cyclist mode tracker plus combinational command legality.
//               Mode and after_init only change on an update strobe
//               (successful completion) or an abort (timeout).
// Ports       : clk_i, rst_i   - clock, synchronous active-high reset
//               chk_op_i        - op code to be checked for legality
//               legal_o         - chk_op_i is legal in the current mode
//               upd_i/upd_op_i  - op upd_op_i completed; advance the mode
//               abort_i         - operation aborted; drop back to NONE
// Revision    : 1.0 - initial release
// ============================================================================
module xoodyak_mode_check
  import xoodyak_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] chk_op_i,
  output logic       legal_o,
  input  logic       upd_i,
  input  logic [3:0] upd_op_i,
  input  logic       abort_i
);

  mode_e mode_q, mode_d;
  logic  after_init_q, after_init_d;

  always_comb begin
    legal_o = legal_cmd(chk_op_i, mode_q, after_init_q);
  end

  always_comb begin
    mode_d       = mode_q;
    after_init_d = after_init_q;
    if (abort_i) begin
      // A timed-out core is in an unknown state; demand a fresh init.
      mode_d       = MODE_NONE;
      after_init_d = 1'b0;
    end else if (upd_i) begin
      after_init_d = (upd_op_i == OP_INIT_KEYED);
      if (upd_op_i == OP_INIT_KEYED) begin
        mode_d = MODE_KEYED;
      end else if (upd_op_i == OP_INIT_HASH) begin
        mode_d = MODE_HASH;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q       <= MODE_NONE;
      after_init_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      after_init_q <= after_init_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xoodyak_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xoodyak_sequencer
// Description : Host command sequencer in front of xoodyak_build.
//               - Checks each command against the Cyclist mode rules.
//               - Holds legal commands on the core pins for HOLD_CYCLES.
//               - Waits (bounded by TIMEOUT) for core_done.
//               - Returns a one-beat response with an error flag.
// Ports       : eph1, reset                       - clock, sync active-high reset
//               cmd_valid/cmd_ready               - host command handshake
//               cmd_op, cmd_cont, cmd_data        - command payload
//               core_opmode, core_data, core_done - xoodyak_build interface
//               resp_valid/resp_ready             - host response handshake
//               resp_err, resp_op                 - response payload
// Revision    : 1.0 - initial release
// ============================================================================
module xoodyak_sequencer
  import xoodyak_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 64,
  parameter int DW          = 352
) (
  input  logic          eph1,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic          cmd_cont,
  input  logic [DW-1:0] cmd_data,
  output logic [4:0]    core_opmode,
  output logic [DW-1:0] core_data,
  input  logic          core_done,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_err,
  output logic [3:0]    resp_op
);

  localparam int HCW = $clog2(HOLD_CYCLES) + 1;
  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           done_seen_q, done_seen_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic [4:0]     opmode_q, opmode_d;
  logic [DW-1:0]  cdata_q, cdata_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_err_q, resp_err_d;
  logic [3:0]     resp_op_q, resp_op_d;

  logic cmd_legal;
  logic mode_upd;
  logic mode_abort;

  // resp_op_q is loaded at accept time, so it doubles as the latched op
  // for the mode update on completion.
  xoodyak_mode_check u_mode_check (
    .clk_i    (eph1),
    .rst_i    (reset),
    .chk_op_i (cmd_op),
    .legal_o  (cmd_legal),
    .upd_i    (mode_upd),
    .upd_op_i (resp_op_q),
    .abort_i  (mode_abort)
  );

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    wcnt_d       = wcnt_q;
    done_seen_d  = done_seen_q;
    opmode_d     = opmode_q;
    cdata_d      = cdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_op_d    = resp_op_q;
    mode_upd     = 1'b0;
    mode_abort   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          resp_op_d = cmd_op;
          if (cmd_legal) begin
            state_d     = ST_ISSUE;
            hcnt_d      = '0;
            done_seen_d = 1'b0;
            opmode_d    = {cmd_cont, cmd_op};
            cdata_d     = cmd_data;
          end else begin
            // Illegal: answer immediately, core and mode untouched.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        // An early completion is remembered; the hold window still runs out.
        if (core_done) begin
          done_seen_d = 1'b1;
        end
        if (hcnt_q == HOLD_LAST) begin
          opmode_d = '0;
          cdata_d  = '0;
          if (done_seen_q || core_done) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            mode_upd     = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = '0;
          end
        end else begin
          hcnt_d = hcnt_q + HCW'(1);
        end
      end

      ST_WAIT: begin
        if (core_done) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          mode_upd     = 1'b1;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          mode_abort   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered ready: low through reset, high the cycle after entering IDLE.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge eph1) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      wcnt_q       <= '0;
      done_seen_q  <= 1'b0;
      cmd_ready_q  <= 1'b0;
      opmode_q     <= '0;
      cdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_op_q    <= '0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      wcnt_q       <= wcnt_d;
      done_seen_q  <= done_seen_d;
      cmd_ready_q  <= cmd_ready_d;
      opmode_q     <= opmode_d;
      cdata_q      <= cdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_op_q    <= resp_op_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign core_opmode = opmode_q;
  assign core_data   = cdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_op     = resp_op_q;

endmodule
`default_nettype wire

// File: tb/tb_xoodyak_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xoodyak_sequencer
// Description : Self-checking bench for xoodyak_sequencer. A small Cyclist
//               mode model predicts legality, response codes and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xoodyak_sequencer;

  localparam int HOLD = 4;
  localparam int TMO  = 64;
  localparam int DW   = 352;

  localparam int M_NONE  = 0;
  localparam int M_HASH  = 1;
  localparam int M_KEYED = 2;

  logic          eph1       = 1'b0;
  logic          reset      = 1'b1;
  logic          cmd_valid  = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op     = '0;
  logic          cmd_cont   = 1'b0;
  logic [DW-1:0] cmd_data   = '0;
  logic [4:0]    core_opmode;
  logic [DW-1:0] core_data;
  logic          core_done  = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_err;
  logic [3:0]    resp_op;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int ref_mode = M_NONE;
  bit ref_ai   = 1'b0;

  xoodyak_sequencer #(
    .HOLD_CYCLES (HOLD),
    .TIMEOUT     (TMO),
    .DW          (DW)
  ) dut (
    .eph1        (eph1),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_cont    (cmd_cont),
    .cmd_data    (cmd_data),
    .core_opmode (core_opmode),
    .core_data   (core_data),
    .core_done   (core_done),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_err    (resp_err),
    .resp_op     (resp_op)
  );

  always #5 eph1 = ~eph1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge eph1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  // Cyclist rules written as op-code sets
  function automatic bit ref_legal(input int op);
    if (op == 1 || op == 9)                      return 1'b1;
    if (op == 2)                                 return ref_ai;
    if (op inside {4, 5, 7, 8})                  return ref_mode == M_KEYED;
    if (op == 3 || op == 6)                      return ref_mode != M_NONE;
    return 1'b0;
  endfunction

  function automatic void ref_complete(input int op);
    if (op == 1) begin
      ref_mode = M_KEYED;
      ref_ai   = 1'b1;
    end else if (op == 9) begin
      ref_mode = M_HASH;
      ref_ai   = 1'b0;
    end else begin
      ref_ai = 1'b0;
    end
  endfunction

  // One full command transaction.
  //   done_after : samples after hold end before core_done is driven (-1 = never)
  //   early      : hold-cycle index at which core_done pulses (-1 = none)
  //   bp         : cycles resp_ready is held low while the response is up
  task automatic run_cmd(input logic [3:0] op, input int done_after, input int early, input int bp);
    logic          cont;
    logic [DW-1:0] data;
    bit            legal;
    bit            timed_out;
    bit            exp_err;
    int            k;
    int            exp_lat;
    cont  = 1'($urandom_range(0, 1));
    data  = rand_data();
    k     = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    legal     = ref_legal(int'(op));
    timed_out = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cont  = cont;
    cmd_data  = data;
    step();
    // Scramble the bus to prove the command was latched
    cmd_valid = 1'b0;
    cmd_op    = 4'($urandom());
    cmd_cont  = 1'($urandom_range(0, 1));
    cmd_data  = rand_data();
    if (legal) begin
      for (int i = 0; i < HOLD; i++) begin
        chk("issue_opmode", core_opmode, {cont, op});
        chk("issue_data", core_data, data);
        chk("issue_no_resp", resp_valid, 0);
        chk("issue_cmd_ready", cmd_ready, 0);
        core_done = (i == early);
        step();
        core_done = 1'b0;
      end
      chk("hold_end_opmode", core_opmode, 0);
      chk("hold_end_data", core_data, 0);
      if (early >= 0) begin
        chk("early_done_resp", resp_valid, 1);
      end else begin
        timed_out = !(done_after >= 0 && done_after < TMO);
        exp_lat   = timed_out ? TMO : done_after + 1;
        k = 0;
        while (resp_valid !== 1'b1 && k < TMO + 10) begin
          chk("wait_opmode", core_opmode, 0);
          core_done = (k == done_after);
          step();
          core_done = 1'b0;
          k++;
        end
        chk("wait_latency", k, exp_lat);
      end
      exp_err = timed_out;
      if (timed_out) begin
        ref_mode = M_NONE;
        ref_ai   = 1'b0;
      end else begin
        ref_complete(int'(op));
      end
    end else begin
      chk("illegal_resp_valid", resp_valid, 1);
      chk("illegal_opmode", core_opmode, 0);
      exp_err = 1'b1;
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_op", resp_op, op);
    chk("resp_err", resp_err, exp_err);
    for (int i = 0; i < bp; i++) begin
      // A host pushing commands while the response is pending must be ignored
      cmd_valid = 1'b1;
      cmd_op    = 4'($urandom_range(1, 9));
      step();
      chk("bp_valid", resp_valid, 1);
      chk("bp_op", resp_op, op);
      chk("bp_err", resp_err, exp_err);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_released", resp_valid, 0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b1;
    step(); step(); step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_opmode", core_opmode, 0);
    chk("rst_data", core_data, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_op", resp_op, 0);
    reset = 1'b0;
    step();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // ---------------- nonce straight after reset ----------------
    run_cmd(4'd2, 3, -1, 0);

    // ---------------- keyed flow ----------------
    run_cmd(4'd1, 3, -1, 0);
    run_cmd(4'd2, 3, -1, 0);
    run_cmd(4'd3, 3, -1, 0);
    run_cmd(4'd4, 3, -1, 0);
    run_cmd(4'd6, 3, -1, 0);

    // ---------------- nonce not directly after init ----------------
    run_cmd(4'd1, 2, -1, 0);
    run_cmd(4'd3, 2, -1, 0);
    run_cmd(4'd2, 2, -1, 0);

    // ---------------- hash flow ----------------
    run_cmd(4'd9, 1, -1, 0);
    run_cmd(4'd4, 1, -1, 0);
    run_cmd(4'd6, 1, -1, 0);

    // ---------------- illegal codes ----------------
    run_cmd(4'd0, 1, -1, 0);
    run_cmd(4'd15, 1, -1, 0);

    // ---------------- timeout ----------------
    run_cmd(4'd1, -1, -1, 0);
    run_cmd(4'd3, 1, -1, 0);

    // ---------------- backpressure and early done ----------------
    run_cmd(4'd1, 4, -1, 10);
    run_cmd(4'd3, -1, 1, 0);
    run_cmd(4'd6, -1, HOLD - 1, 2);
    run_cmd(4'd4, TMO - 1, -1, 0);

    // ---------------- reset mid-WAIT ----------------
    begin
      int k;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 20) begin
        step();
        k++;
      end
      cmd_valid = 1'b1;
      cmd_op    = 4'd1;
      cmd_cont  = 1'b1;
      cmd_data  = rand_data();
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < HOLD + 3; i++) step();
      reset = 1'b1;
      step();
      chk("midrst_opmode", core_opmode, 0);
      chk("midrst_data", core_data, 0);
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_resp_err", resp_err, 0);
      chk("midrst_resp_op", resp_op, 0);
      chk("midrst_cmd_ready", cmd_ready, 0);
      reset    = 1'b0;
      ref_mode = M_NONE;
      ref_ai   = 1'b0;
      // A late done from the abandoned command must not produce a response
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
        chk("midrst_no_resp", resp_valid, 0);
        step();
      end
      chk("midrst_ready", cmd_ready, 1);
    end
    run_cmd(4'd3, 1, -1, 0);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      int         early;
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
      else                           op = 4'($urandom_range(1, 9));
      early = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, HOLD - 1)) : -1;
      run_cmd(op, int'($urandom_range(0, 8)), early, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
